// File: rtl/cordic_phase_sequencer_if.sv
// Result stream from the CORDIC phase sequencer to its consumer (DAC formatter / Avalon bridge).
interface cordic_phase_sequencer_if;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_angle;
  logic [15:0] m_cos;
  logic [15:0] m_sin;

  modport master (output m_valid, m_angle, m_cos, m_sin, input m_ready);
  modport slave  (input m_valid, m_angle, m_cos, m_sin, output m_ready);
endinterface

// File: rtl/cordic_phase_sequencer.sv
// Phase-ramp launcher for a CORDIC rotation stage with a show-ahead result FIFO.
// Optional WAIT watchdog is compiled in with `define CORDIC_SEQ_TIMEOUT_EN.
module cordic_phase_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [15:0]                 phase_inc,
  input  logic [15:0]                 phase_offset,
  output logic                        cordic_start,
  output logic [15:0]                 cordic_angle,
  input  logic                        cordic_done,
  input  logic [15:0]                 cordic_cos,
  input  logic [15:0]                 cordic_sin,
  cordic_phase_sequencer_if.master    m,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cordic_phase_sequencer: FIFO_DEPTH must be a power of two in 2..16, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, STORE} state_t;
  typedef struct packed {
    logic [15:0] angle;
    logic [15:0] cos_v;
    logic [15:0] sin_v;
  } entry_t;

  state_t        state;
  logic [15:0]   acc, res_cos, res_sin;
  logic          wait_first;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign push = (state == STORE);
  assign pop  = m.m_valid && m.m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      cordic_start <= 1'b0;
      cordic_angle <= '0;
      wait_first   <= 1'b0;
      res_cos      <= '0;
      res_sin      <= '0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      cordic_start <= 1'b0;
      unique case (state)
        IDLE: begin
          // Space is reserved at launch; occupancy cannot rise while in flight.
          if (enable && fifo_count < DEPTH_C) begin
            state        <= LAUNCH;
            cordic_start <= 1'b1;
            cordic_angle <= acc + phase_offset;
          end
        end
        LAUNCH: begin
          state      <= WAIT;
          wait_first <= 1'b1;
`ifdef CORDIC_SEQ_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end
        WAIT: begin
          wait_first <= 1'b0;
          // done on the first WAIT cycle is left over from the previous request
          if (cordic_done && !wait_first) begin
            state   <= STORE;
            res_cos <= cordic_cos;
            res_sin <= cordic_sin;
          end
`ifdef CORDIC_SEQ_TIMEOUT_EN
          else if (wait_cnt == TLAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        STORE: begin
          acc   <= acc + phase_inc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{angle: cordic_angle, cos_v: res_cos, sin_v: res_sin};
  end

  assign head      = mem[rd_ptr];
  assign m.m_valid = (fifo_count != '0);
  assign m.m_angle = head.angle;
  assign m.m_cos   = head.cos_v;
  assign m.m_sin   = head.sin_v;
endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Self-checking bench: CORDIC model with 17-cycle done latency, scoreboard on the result stream.
module tb_cordic_phase_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] phase_inc = '0, phase_offset = '0;
  logic        cordic_start;
  logic [15:0] cordic_angle;
  logic        cdone = 1'b0;
  logic [15:0] ccos = '0, csin = '0, cangle = '0;
  logic [2:0]  fifo_count;
  logic        busy, timeout_err;

  cordic_phase_sequencer_if sif();

  cordic_phase_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .phase_inc(phase_inc), .phase_offset(phase_offset),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_done(cdone), .cordic_cos(ccos), .cordic_sin(csin),
    .m(sif), .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // CORDIC model: done is a level that clears when start is seen (one cycle later if stale_hold)
  bit stale_hold = 1'b0, never_done = 1'b0, clr_pend = 1'b0;
  int ccnt = 0;
  always @(posedge clk) begin
    if (cordic_start) begin
      ccnt   <= 16;
      cangle <= cordic_angle;
      if (stale_hold) clr_pend <= 1'b1;
      else cdone <= 1'b0;
    end else begin
      if (clr_pend) begin cdone <= 1'b0; clr_pend <= 1'b0; end
      if (ccnt > 0) begin
        ccnt <= ccnt - 1;
        if (ccnt == 1 && !never_done) begin
          cdone <= 1'b1;
          ccos  <= cangle;
          csin  <= ~cangle;
        end
      end
    end
  end

  typedef struct packed { logic [15:0] a, c, s; } ent_t;
  ent_t q[$];
  ent_t e;
  bit   sb_en = 1'b0, chk_spacing = 1'b0, have_prev = 1'b0;
  int   cyc = 0, prev_launch = 0, launches = 0, pops = 0;
  logic [15:0] m_acc = '0, exp_a, last_angle = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_acc     = '0;
      have_prev = 1'b0;
    end else begin
      if (cordic_start) begin
        launches++;
        if (sb_en) begin
          exp_a = m_acc + phase_offset;
          check("launch_angle", 32'(cordic_angle), 32'(exp_a));
          q.push_back('{a: exp_a, c: exp_a, s: ~exp_a});
          m_acc = m_acc + phase_inc;
          if (chk_spacing && have_prev) check("launch_spacing", cyc - prev_launch, 20);
          have_prev   = 1'b1;
          prev_launch = cyc;
        end
      end
      if (sif.m_valid && sif.m_ready) begin
        pops++;
        last_angle = sif.m_angle;
        if (sb_en) begin
          if (q.size() == 0) begin
            check("pop_unexpected", 32'(sif.m_angle), 32'hDEAD_0000);
          end else begin
            e = q.pop_front();
            check("m_angle", 32'(sif.m_angle), 32'(e.a));
            check("m_cos", 32'(sif.m_cos), 32'(e.c));
            check("m_sin", 32'(sif.m_sin), 32'(e.s));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; sif.m_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_start", 32'(cordic_start), 0);
    check("rst_angle", 32'(cordic_angle), 0);
    check("rst_m_valid", 32'(sif.m_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    launches = 0; pops = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    enable = 1'b0; sif.m_ready = 1'b1;
    for (int i = 0; i < 100 && (busy || sif.m_valid); i++) tick();
    @(negedge clk);
    check("drained_busy", 32'(busy), 0);
    check("drained_queue", q.size(), 0);
  endtask

  typedef struct {
    logic [15:0] inc, off;
    int          n;
    bit          stale;
    logic [15:0] exp_last;
  } vec_t;
  vec_t vecs[5];

  logic [15:0] a0;

  initial begin
    vecs[0] = '{16'h0400, 16'h0000, 65, 1'b0, 16'h0000};
    vecs[1] = '{16'h1234, 16'h8000,  5, 1'b0, 16'hC8D0};
    vecs[2] = '{16'hFFFF, 16'h0005,  3, 1'b0, 16'h0003};
    vecs[3] = '{16'h8000, 16'h7FFF,  4, 1'b0, 16'hFFFF};
    vecs[4] = '{16'h0100, 16'h0010,  4, 1'b1, 16'h0310};
    sif.m_ready = 1'b0;

    // Continuous ramps with a free-running consumer
    foreach (vecs[k]) begin
      do_reset();
      phase_inc = vecs[k].inc; phase_offset = vecs[k].off; stale_hold = vecs[k].stale;
      sb_en = 1'b1; chk_spacing = 1'b1; sif.m_ready = 1'b1; enable = 1'b1;
      for (int i = 0; i < 30 * vecs[k].n + 50 && launches < vecs[k].n; i++) tick();
      enable = 1'b0;
      drain();
      check("row_launches", launches, vecs[k].n);
      check("row_pops", pops, vecs[k].n);
      check("row_last_angle", 32'(last_angle), 32'(vecs[k].exp_last));
    end
    stale_hold = 1'b0;

    // Full FIFO: saturate, then one pop buys exactly one launch
    do_reset();
    phase_inc = 16'h0400; phase_offset = 16'h0000; chk_spacing = 1'b0; enable = 1'b1;
    for (int i = 0; i < 200 && fifo_count != 3'd4; i++) tick();
    @(negedge clk);
    check("full_count", 32'(fifo_count), 4);
    a0 = 16'(launches);
    for (int i = 0; i < 60; i++) tick();
    check("full_no_launch", launches - int'(a0), 0);
    check("full_hold", 32'(fifo_count), 4);
    sif.m_ready = 1'b1; tick(); sif.m_ready = 1'b0;
    a0 = 16'(launches);
    for (int i = 0; i < 60; i++) tick();
    check("one_relaunch", launches - int'(a0), 1);
    check("refull", 32'(fifo_count), 4);
    drain();

    // Simultaneous push and pop with one entry resident
    do_reset();
    phase_inc = 16'h0400; phase_offset = 16'h0011; chk_spacing = 1'b1; enable = 1'b1;
    for (int i = 0; i < 100 && launches < 2; i++) tick();
    check("pp_count_first", 32'(fifo_count), 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cdone) break;
    end
    tick();
    sif.m_ready = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("pp_count_store", 32'(fifo_count), 1);
    @(negedge clk);
    check("pp_count_after", 32'(fifo_count), 1);
    drain();
    check("pp_pops", pops, 2);

    // Reset during WAIT, then a late done must be ignored
    do_reset();
    phase_inc = 16'h0100; phase_offset = 16'h0123; chk_spacing = 1'b0;
    sif.m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 20 && launches < 1; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0; launches = 0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    for (int i = 0; i < 30; i++) tick();
    check("late_done_count", 32'(fifo_count), 0);
    check("late_done_valid", 32'(sif.m_valid), 0);
    check("late_done_busy", 32'(busy), 0);
    check("late_done_launch", launches, 0);
    enable = 1'b1;
    for (int i = 0; i < 20 && launches < 1; i++) tick();
    enable = 1'b0;
    check("post_rst_angle", 32'(cordic_angle), 32'h0123);
    drain();
    check("post_rst_pops", pops, 1);

    // Watchdog: a CORDIC that never completes
    do_reset();
    sb_en = 1'b0; never_done = 1'b1;
    phase_inc = 16'h0400; phase_offset = 16'h0ABC; sif.m_ready = 1'b1; enable = 1'b1;
`ifdef CORDIC_SEQ_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cordic_start) break;
    end
    a0 = cordic_angle;
    check("to_first_angle", 32'(a0), 32'h0ABC);
    repeat (64) @(negedge clk);
    check("to_err_before", 32'(timeout_err), 0);
    check("to_busy_before", 32'(busy), 1);
    @(negedge clk);
    check("to_err_set", 32'(timeout_err), 1);
    check("to_idle", 32'(busy), 0);
    @(negedge clk);
    check("to_relaunch", 32'(cordic_start), 1);
    check("to_relaunch_angle", 32'(cordic_angle), 32'(a0));
    tick();
    enable = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("to_sticky", 32'(timeout_err), 1);
    check("to_no_push", 32'(fifo_count), 0);
`else
    for (int i = 0; i < 100; i++) tick();
    check("no_timeout", 32'(timeout_err), 0);
    check("wait_forever", 32'(busy), 1);
    check("no_push", 32'(fifo_count), 0);
`endif
    never_done = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/cordic_phase_sequencer.md
# cordic_phase_sequencer

Upstream driver and result buffer for the `cordic` rotation stage. It generates a phase ramp from a programmable increment and issues one `start`/`angle` request to the CORDIC at a time. It captures `cos_out`/`sin_out` when `done` rises and queues each `{angle, cos, sin}` triple in a small FIFO. A valid/ready stream presents the queued triples to the downstream consumer (DAC formatter or Avalon bridge).

## Interface
- `FIFO_DEPTH`, 4: result entries buffered; power of two, 2..16.
- `TIMEOUT_CYCLES`, 64: WAIT cycles without `done` before a timeout; used only with the watchdog compiled in.
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high; sampled on `posedge clk`.
- `enable` in 1: permits new launches; does not abort an in-flight request.
- `phase_inc` in 16: accumulator step, unsigned, modulo 2^16.
- `phase_offset` in 16: added to the accumulator to form the issued angle.
- `cordic_start` out 1: one-cycle request pulse to the CORDIC.
- `cordic_angle` out 16: angle issued with `cordic_start`; held until the next launch.
- `cordic_done` in 1: CORDIC completion level.
- `cordic_cos` in 16: CORDIC cosine result.
- `cordic_sin` in 16: CORDIC sine result.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts the head entry when high together with `m_valid`.
- `m_angle`, `m_cos`, `m_sin` out 16 each: FIFO head, show-ahead; contents undefined when `m_valid`=0.
- `fifo_count` out log2(FIFO_DEPTH)+1: current occupancy.
- `busy` out 1: FSM not in IDLE.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- Phase accumulator `acc` is 16 bits and resets to 0.
  - Issued angle = `(acc + phase_offset) mod 2^16`.
  - `acc <= acc + phase_inc` (wraps) only in STORE.
- FSM states: IDLE, LAUNCH, WAIT, STORE.
  - IDLE -> LAUNCH when `enable`=1 and `fifo_count` < FIFO_DEPTH.
  - LAUNCH, exactly 1 cycle: `cordic_start`=1 and `cordic_angle` is registered to the issued angle. Go to WAIT.
  - WAIT: `cordic_done` is ignored on the first WAIT cycle, because a stale `done` from the previous computation is still high there. From the second WAIT cycle on, `cordic_done`=1 -> STORE.
  - STORE, 1 cycle: push `{cordic_angle, cordic_cos, cordic_sin}` into the FIFO, advance `acc`, go to IDLE.
- Only one request is ever in flight.
- FIFO space is checked at launch. Because occupancy can only drop while a request is in flight, the STORE push can never overflow.
- FIFO push and pop:
  - Pop when `m_valid && m_ready`.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
  - A pop on an empty FIFO is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- `phase_inc` and `phase_offset` are sampled at the cycle of use. Changes mid-transaction affect only the next launch.
- `enable` falling during WAIT: the current result still completes and is stored; no further launch.
- Reset mid-operation: FSM returns to IDLE, `acc`, FIFO and `timeout_err` clear, and `cordic_start` drops the same cycle. Any late CORDIC `done` is ignored because the FSM is not in WAIT.

## Timing
- Reset values:
  - `cordic_start`=0, `cordic_angle`=0
  - `m_valid`=0, `fifo_count`=0
  - `busy`=0, `timeout_err`=0
- `cordic_start` is registered and high during the LAUNCH cycle only.
- With a 16-iteration CORDIC, `cordic_done` rises 17 cycles after the LAUNCH edge.
- Entry visibility: the FIFO entry appears (`m_valid`=1) on the cycle after STORE.
- Throughput: one sample per (launch-to-done latency + 3) cycles, which is 20 cycles with the 16-iteration CORDIC.
- `m_valid` and `m_*` are driven from registers and the FIFO array, with no combinational path from `m_ready`.

## Configuration
- Macro: `CORDIC_SEQ_TIMEOUT_EN`.
- Defined:
  - A WAIT cycle counter starts at 0 on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without `done`, the FSM returns to IDLE and `timeout_err` is set (sticky until reset).
  - Nothing is pushed and `acc` is not advanced, so the same angle is retried.
- Undefined: WAIT lasts indefinitely, `timeout_err` is tied 0, and the counter is not built.

## Test plan
- Basic ramp. Stimulus: reset, then `phase_inc`=16'h0400, `phase_offset`=0, `enable`=1. The bench CORDIC model returns `done` 17 cycles after `start`, with cos=angle and sin=~angle. Required: `m_angle` sequence 0x0000, 0x0400, 0x0800, …, wrapping at 0x0000 after 64 samples, with launches exactly 20 cycles apart.
- Stale done. Stimulus: model holds `done`=1 through the first WAIT cycle. Required: no STORE on that cycle; the entry is captured only after `done` reasserts.
- Full FIFO. Stimulus: `m_ready`=0, FIFO_DEPTH=4. Required: `fifo_count` saturates at 4, `cordic_start` stays 0 afterward, and one pop allows exactly one further launch.
- Simultaneous push/pop. Stimulus: `m_ready`=1 held, count=1 at STORE. Required: count remains 1 and order is preserved.
- Reset mid-WAIT. Stimulus: reset asserted 5 cycles after LAUNCH. Required: next cycle has `busy`=0, `fifo_count`=0, first issued angle `phase_offset`, and a late `done` has no effect.
- Timeout (`CORDIC_SEQ_TIMEOUT_EN` defined). Stimulus: model never asserts `done`. Required: `timeout_err`=1 after 64 WAIT cycles, then a relaunch with an unchanged angle.
